// File: rtl/core_pkg.sv
// Shared widths and control-word bit map for the RV32I pipeline.
package core_pkg;
   localparam int XLEN   = 32;
   localparam int REG_W  = 5;
   localparam int CTRL_W = 10;

   localparam int CTRL_REGWRITE  = 0;
   localparam int CTRL_MEMREAD   = 1;
   localparam int CTRL_MEMWRITE  = 2;
   localparam int CTRL_MEMTOREG  = 3;
   localparam int CTRL_ALUSRC    = 4;
   localparam int CTRL_BRANCH    = 5;
   localparam int CTRL_JUMP      = 6;
   localparam int CTRL_ALUOP_LSB = 7;
   localparam int CTRL_ALUOP_MSB = 9;

   typedef logic [REG_W-1:0] reg_idx_t;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard: a load in EX whose rd feeds the instruction in ID.
module load_use_detect
   import core_pkg::*;
(
   input  logic     id_valid,
   input  reg_idx_t id_rs1,
   input  reg_idx_t id_rs2,
   input  logic     id_uses_rs1,
   input  logic     id_uses_rs2,
   input  logic     ex_valid,
   input  logic     ex_memread,
   input  reg_idx_t ex_rd,
   output logic     hz
);
   logic src_match;

   assign src_match = (id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd));
   // x0 is never really written, so a load targeting it cannot create a dependency
   assign hz = id_valid && ex_valid && ex_memread && (ex_rd != '0) && src_match;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, EX flush bubbles and
// saturating stall/bubble counters.
module id_ex_stage
   import core_pkg::*;
#(
   parameter int XLEN_P = XLEN,
   parameter int CTRL_W_P = CTRL_W,
   parameter int CNT_W  = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_valid,
   input  logic [XLEN_P-1:0]   id_pc,
   input  logic [REG_W-1:0]    id_rs1,
   input  logic [REG_W-1:0]    id_rs2,
   input  logic [REG_W-1:0]    id_rd,
   input  logic                id_uses_rs1,
   input  logic                id_uses_rs2,
   input  logic [XLEN_P-1:0]   id_rd1,
   input  logic [XLEN_P-1:0]   id_rd2,
   input  logic [XLEN_P-1:0]   id_imm,
   input  logic [CTRL_W_P-1:0] id_ctrl,
   input  logic                ex_flush,
   output logic                stall,
   output logic                ex_valid,
   output logic [XLEN_P-1:0]   ex_pc,
   output logic [REG_W-1:0]    ex_rs1,
   output logic [REG_W-1:0]    ex_rs2,
   output logic [REG_W-1:0]    ex_rd,
   output logic [XLEN_P-1:0]   ex_rd1,
   output logic [XLEN_P-1:0]   ex_rd2,
   output logic [XLEN_P-1:0]   ex_imm,
   output logic [CTRL_W_P-1:0] ex_ctrl,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    bubble_cnt
);
   logic                valid_q, valid_d;
   logic [XLEN_P-1:0]   pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
   logic [REG_W-1:0]    rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [CTRL_W_P-1:0] ctrl_q, ctrl_d, id_ctrl_guarded;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
   logic                hz, bubble;

   load_use_detect u_hz (
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_valid    (valid_q),
      .ex_memread  (ctrl_q[CTRL_MEMREAD]),
      .ex_rd       (rd_q),
      .hz          (hz)
   );

   assign stall  = hz && !ex_flush;
   assign bubble = ex_flush || stall;

   // The register file does not protect x0, so its write enable is dropped here
   always_comb begin
      id_ctrl_guarded = id_ctrl;
      if (id_rd == '0)
         id_ctrl_guarded[CTRL_REGWRITE] = 1'b0;
   end

   always_comb begin
      valid_d      = valid_q;
      pc_d         = pc_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      rd_d         = rd_q;
      rd1_d        = rd1_q;
      rd2_d        = rd2_q;
      imm_d        = imm_q;
      ctrl_d       = ctrl_q;
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (bubble) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else begin
         valid_d = id_valid;
         pc_d    = id_pc;
         rs1_d   = id_rs1;
         rs2_d   = id_rs2;
         rd_d    = id_rd;
         rd1_d   = id_rd1;
         rd2_d   = id_rd2;
         imm_d   = id_imm;
         ctrl_d  = id_valid ? id_ctrl_guarded : '0;
      end
      if (stall && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (bubble && (bubble_cnt_q != '1))
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         pc_q         <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rd_q         <= '0;
         rd1_q        <= '0;
         rd2_q        <= '0;
         imm_q        <= '0;
         ctrl_q       <= '0;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         valid_q      <= valid_d;
         pc_q         <= pc_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         rd_q         <= rd_d;
         rd1_q        <= rd1_d;
         rd2_q        <= rd2_d;
         imm_q        <= imm_d;
         ctrl_q       <= ctrl_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign ex_valid   = valid_q;
   assign ex_pc      = pc_q;
   assign ex_rs1     = rs1_q;
   assign ex_rs2     = rs2_q;
   assign ex_rd      = rd_q;
   assign ex_rd1     = rd1_q;
   assign ex_rd2     = rd2_q;
   assign ex_imm     = imm_q;
   assign ex_ctrl    = ctrl_q;
   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Vector table plus scoreboard bench for id_ex_stage (narrow counters to reach saturation).
module tb_id_ex_stage;
   localparam int CW = 4;
   localparam logic [CW-1:0] CMAX = '1;
   localparam logic [9:0] C_RW   = 10'h001;
   localparam logic [9:0] C_LOAD = 10'h01B;
   localparam logic [9:0] C_ADD  = 10'h081;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid = 1'b0, id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_flush = 1'b0;
   logic [31:0] id_pc = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic [9:0]  id_ctrl = '0;
   logic        stall, ex_valid;
   logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [9:0]  ex_ctrl;
   logic [CW-1:0] stall_cnt, bubble_cnt;

   always #5 clk = ~clk;

   id_ex_stage #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
      .ex_flush(ex_flush), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rd1(ex_rd1),
      .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   typedef struct {
      logic v; logic [31:0] pc; logic [4:0] rs1, rs2, rd; logic u1, u2;
      logic [31:0] rd1, rd2, imm; logic [9:0] ctrl; logic flush;
      logic exp_stall; logic exp_valid; logic [9:0] exp_ctrl;
   } vec_t;

   typedef struct {
      int idx; logic bubble; logic valid; logic [9:0] ctrl;
      logic [31:0] pc, rd1, rd2, imm; logic [4:0] rs1, rs2, rd;
   } exp_t;

   exp_t q[$];
   vec_t tbl[15];
   int checks = 0, failures = 0;
   logic [CW-1:0] stall_m = '0, bub_m = '0;

   function automatic vec_t mk(input logic v, input logic [31:0] pc,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic u1, input logic u2, input logic [9:0] ctrl,
                               input logic flush, input logic es, input logic ev,
                               input logic [9:0] ec);
      vec_t t;
      t.v = v; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.u1 = u1; t.u2 = u2;
      t.rd1 = pc + 32'd1; t.rd2 = ~pc; t.imm = {pc[15:0], 16'hFFF0};
      t.ctrl = ctrl; t.flush = flush; t.exp_stall = es; t.exp_valid = ev; t.exp_ctrl = ec;
      return t;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s txn=%0d actual=0x%0h expected=0x%0h", nm, idx, act, exp);
      end
   endtask

   task automatic step(input vec_t t, input int idx);
      exp_t e;
      @(negedge clk);
      id_valid = t.v; id_pc = t.pc; id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
      id_uses_rs1 = t.u1; id_uses_rs2 = t.u2; id_rd1 = t.rd1; id_rd2 = t.rd2;
      id_imm = t.imm; id_ctrl = t.ctrl; ex_flush = t.flush;
      #1;
      chk("stall", idx, {31'd0, stall}, {31'd0, t.exp_stall});
      e.idx = idx; e.bubble = t.flush || t.exp_stall; e.valid = t.exp_valid; e.ctrl = t.exp_ctrl;
      e.pc = t.pc; e.rd1 = t.rd1; e.rd2 = t.rd2; e.imm = t.imm;
      e.rs1 = t.rs1; e.rs2 = t.rs2; e.rd = t.rd;
      q.push_back(e);
      if (t.exp_stall && stall_m != CMAX) stall_m++;
      if ((t.exp_stall || t.flush) && bub_m != CMAX) bub_m++;
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         checks++; failures++;
         $display("FAIL scoreboard txn=%0d actual=empty expected=entry", idx);
      end else begin
         e = q.pop_front();
         chk("ex_valid", e.idx, {31'd0, ex_valid}, {31'd0, e.valid});
         chk("ex_ctrl", e.idx, {22'd0, ex_ctrl}, {22'd0, e.ctrl});
         if (!e.bubble) begin
            chk("ex_pc", e.idx, ex_pc, e.pc);
            chk("ex_rd1", e.idx, ex_rd1, e.rd1);
            chk("ex_rd2", e.idx, ex_rd2, e.rd2);
            chk("ex_imm", e.idx, ex_imm, e.imm);
            chk("ex_regs", e.idx, {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, e.rs1, e.rs2, e.rd});
         end
         chk("stall_cnt", e.idx, {28'd0, stall_cnt}, {28'd0, stall_m});
         chk("bubble_cnt", e.idx, {28'd0, bubble_cnt}, {28'd0, bub_m});
         $display("txn %0d pc=0x%0h stall=%0b ex_valid=%0b ex_ctrl=0x%0h cnt=%0d/%0d",
                  e.idx, ex_pc, t.exp_stall, ex_valid, ex_ctrl, stall_cnt, bubble_cnt);
      end
   endtask

   initial begin
      //            v  pc           rs1 rs2 rd u1 u2 ctrl    fl  st ev ectrl
      tbl[0]  = mk(1, 32'h100, 5'd1, 5'd2, 5'd3, 1, 1, C_RW,   0, 0, 1, C_RW);
      tbl[0].rd1 = 32'h5; tbl[0].rd2 = 32'hA; tbl[0].imm = 32'hFFFF_FFF0;
      tbl[1]  = mk(1, 32'h104, 5'd2, 5'd0, 5'd5, 1, 0, C_LOAD, 0, 0, 1, C_LOAD);
      tbl[2]  = mk(1, 32'h108, 5'd5, 5'd1, 5'd6, 1, 1, C_ADD,  0, 1, 0, 10'h000);
      tbl[3]  = mk(1, 32'h108, 5'd5, 5'd1, 5'd6, 1, 1, C_ADD,  0, 0, 1, C_ADD);
      tbl[4]  = mk(1, 32'h10C, 5'd6, 5'd0, 5'd0, 1, 0, C_LOAD, 0, 0, 1, 10'h01A);
      tbl[5]  = mk(1, 32'h110, 5'd0, 5'd0, 5'd7, 1, 0, C_ADD,  0, 0, 1, C_ADD);
      tbl[6]  = mk(1, 32'h114, 5'd7, 5'd0, 5'd5, 0, 0, C_LOAD, 0, 0, 1, C_LOAD);
      tbl[7]  = mk(1, 32'h118, 5'd1, 5'd5, 5'd8, 1, 0, C_ADD,  0, 0, 1, C_ADD);
      tbl[8]  = mk(1, 32'h11C, 5'd2, 5'd0, 5'd5, 1, 0, C_LOAD, 0, 0, 1, C_LOAD);
      tbl[9]  = mk(1, 32'h120, 5'd5, 5'd0, 5'd9, 1, 0, C_ADD,  1, 0, 0, 10'h000);
      tbl[10] = mk(0, 32'h124, 5'd1, 5'd2, 5'd4, 1, 1, C_ADD,  0, 0, 0, 10'h000);
      tbl[11] = mk(1, 32'h128, 5'd1, 5'd2, 5'd0, 1, 1, C_RW,   0, 0, 1, 10'h000);
      tbl[12] = mk(1, 32'h12C, 5'd1, 5'd0, 5'd9, 1, 0, C_LOAD, 0, 0, 1, C_LOAD);
      tbl[13] = mk(1, 32'h130, 5'd3, 5'd9, 5'd10, 1, 1, C_ADD, 0, 1, 0, 10'h000);
      tbl[14] = mk(1, 32'h130, 5'd3, 5'd9, 5'd10, 1, 1, C_ADD, 0, 0, 1, C_ADD);

      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", -1, {31'd0, ex_valid}, 32'd0);
      chk("reset_stall", -1, {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) step(tbl[i], i);

      // asynchronous reset mid-run, observed before any clock edge
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", 100, {31'd0, ex_valid}, 32'd0);
      chk("arst_pc", 100, ex_pc, 32'd0);
      chk("arst_ctrl", 100, {22'd0, ex_ctrl}, 32'd0);
      chk("arst_data", 100, ex_rd1 | ex_rd2 | ex_imm, 32'd0);
      chk("arst_stall", 100, {31'd0, stall}, 32'd0);
      chk("arst_cnt", 100, {24'd0, stall_cnt, bubble_cnt}, 32'd0);
      stall_m = '0; bub_m = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // repeated load-use pairs drive both counters into saturation
      for (int i = 0; i < 17; i++) begin
         step(mk(1, 32'h200 + 32'(i * 16), 5'd1, 5'd0, 5'd5, 1, 0, C_LOAD, 0, 0, 1, C_LOAD), 200 + i * 3);
         step(mk(1, 32'h204 + 32'(i * 16), 5'd5, 5'd2, 5'd6, 1, 1, C_ADD, 0, 1, 0, 10'h000), 201 + i * 3);
         step(mk(1, 32'h204 + 32'(i * 16), 5'd5, 5'd2, 5'd6, 1, 1, C_ADD, 0, 0, 1, C_ADD), 202 + i * 3);
      end
      chk("sat_stall", 300, {28'd0, stall_cnt}, {28'd0, CMAX});
      chk("sat_bubble", 300, {28'd0, bubble_cnt}, {28'd0, CMAX});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
